// File: rtl/branch_target_predictor.sv
// Branch target buffer with 2-bit saturating direction counters and a
// saturating mispredict counter. Lookup is combinational from the current
// fetch PC; resolved branches train the table through the update port.
module branch_target_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic [ADDR_W-1:0] lookup_pc_in,
  output logic              pred_taken_out,
  output logic [ADDR_W-1:0] pred_target_out,
  input  logic              update_valid_in,
  input  logic [ADDR_W-1:0] update_pc_in,
  input  logic              update_taken_in,
  input  logic [ADDR_W-1:0] update_target_in,
  input  logic              update_pred_in,
  input  logic              flush_in,
  output logic [CNT_W-1:0]  mispredict_cnt_out
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  // Table storage
  logic              valid_q  [ENTRIES];
  ctr_e              ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  mis_cnt_q;

  // Lookup-side decode
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  // Update-side decode
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_alloc;
  logic             up_train;
  logic             up_mispredict;

  // Byte-offset bits of the PCs do not take part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc_in[1:0], update_pc_in[1:0]};

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
  endfunction

  assign lk_idx = lookup_pc_in[IDX_W+1:2];
  assign lk_tag = lookup_pc_in[ADDR_W-1:IDX_W+2];
  assign up_idx = update_pc_in[IDX_W+1:2];
  assign up_tag = update_pc_in[ADDR_W-1:IDX_W+2];

  // Predict from the registered table; a same-cycle update is not forwarded.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pred_taken_out  = 1'b0;
    pred_target_out = lookup_pc_in + ADDR_W'(4);
    lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    if (lk_hit && (ctr_q[lk_idx] inside {WEAK_T, STRONG_T})) begin
      pred_taken_out  = 1'b1;
      pred_target_out = target_q[lk_idx];
    end
  end

  // Classify the resolved branch: train an existing entry or allocate on taken.
  // A flush in the same cycle suppresses all table writes.
  always_comb begin
    up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_train      = update_valid_in && !flush_in && up_hit;
    up_alloc      = update_valid_in && !flush_in && !up_hit && update_taken_in;
    up_mispredict = update_valid_in && (update_taken_in != update_pred_in);
  end

  // Valid bits and direction counters: reset, flush, allocate, train.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WEAK_NT;
      end
    end else if (flush_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (up_alloc) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= WEAK_T;
    end else if (up_train) begin
      ctr_q[up_idx] <= update_taken_in ? ctr_inc(ctr_q[up_idx]) : ctr_dec(ctr_q[up_idx]);
    end
  end

  // Tags and targets: written on allocation, target refreshed on a taken hit.
  // NOTE: tag/target arrays carry no reset; they are only observed through a valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (up_alloc) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= update_target_in;
    end else if (up_train && update_taken_in) begin
      target_q[up_idx] <= update_target_in;
    end
  end

  // Mispredict statistics: saturating, cleared only by reset, unaffected by flush.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      mis_cnt_q <= '0;
    end else if (up_mispredict && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign mispredict_cnt_out = mis_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed vector table, hand-written
// saturation/reset sequences, and randomized traffic against an entry-level
// model. A second instance with CNT_W=4 shares all inputs to exercise
// counter saturation.
module tb_branch_target_predictor;

  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic              clk = 1'b0;
  logic              reset_in = 1'b0;
  logic [ADDR_W-1:0] lookup_pc_in = '0;
  logic              update_valid_in = 1'b0;
  logic [ADDR_W-1:0] update_pc_in = '0;
  logic              update_taken_in = 1'b0;
  logic [ADDR_W-1:0] update_target_in = '0;
  logic              update_pred_in = 1'b0;
  logic              flush_in = 1'b0;

  logic              pred_taken_out, sat_pred_taken;
  logic [ADDR_W-1:0] pred_target_out, sat_pred_target;
  logic [15:0]       mispredict_cnt_out;
  logic [3:0]        sat_mis_cnt;

  always #5 clk = ~clk;

  branch_target_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(16)) dut (
    .clk(clk), .reset_in(reset_in), .lookup_pc_in(lookup_pc_in),
    .pred_taken_out(pred_taken_out), .pred_target_out(pred_target_out),
    .update_valid_in(update_valid_in), .update_pc_in(update_pc_in),
    .update_taken_in(update_taken_in), .update_target_in(update_target_in),
    .update_pred_in(update_pred_in), .flush_in(flush_in),
    .mispredict_cnt_out(mispredict_cnt_out)
  );

  branch_target_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(4)) dut_sat (
    .clk(clk), .reset_in(reset_in), .lookup_pc_in(lookup_pc_in),
    .pred_taken_out(sat_pred_taken), .pred_target_out(sat_pred_target),
    .update_valid_in(update_valid_in), .update_pc_in(update_pc_in),
    .update_taken_in(update_taken_in), .update_target_in(update_target_in),
    .update_pred_in(update_pred_in), .flush_in(flush_in),
    .mispredict_cnt_out(sat_mis_cnt)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (one record per table slot) ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_block [ENTRIES];  // pc >> (IDX_W+2) of the owning branch
  logic [31:0] m_tgt   [ENTRIES];
  int          m_str   [ENTRIES];  // 0..3, taken when >= 2
  int          m_mis;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_block[slot(pc)] == (pc >> (IDX_W + 2)));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_str[i]   = 1;
      m_block[i] = '0;
      m_tgt[i]   = '0;
    end
    m_mis = 0;
  endfunction

  function automatic void model_update(input bit uv, input logic [31:0] upc, input bit ut,
                                       input logic [31:0] utgt, input bit upred, input bit fl);
    int s;
    s = slot(upc);
    if (uv && (ut != upred)) m_mis++;
    if (fl) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (m_hit(upc)) begin
        if (ut) begin
          m_str[s] = (m_str[s] < 3) ? m_str[s] + 1 : 3;
          m_tgt[s] = utgt;
        end else begin
          m_str[s] = (m_str[s] > 0) ? m_str[s] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[s] = 1'b1;
        m_block[s] = upc >> (IDX_W + 2);
        m_tgt[s]   = utgt;
        m_str[s]   = 2;
      end
    end
  endfunction

  // Drive one cycle's inputs away from the rising edge and compare both instances.
  task automatic apply_and_check(input string name, input logic [31:0] lpc, input bit uv,
                                 input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                                 input bit upred, input bit fl, input bit et,
                                 input logic [31:0] etgt, input int ecnt);
    int ecnt_main, ecnt_sat;
    @(negedge clk);
    lookup_pc_in     = lpc;
    update_valid_in  = uv;
    update_pc_in     = upc;
    update_taken_in  = ut;
    update_target_in = utgt;
    update_pred_in   = upred;
    flush_in         = fl;
    #1;
    ecnt_main = (ecnt > 65535) ? 65535 : ecnt;
    ecnt_sat  = (ecnt > 15) ? 15 : ecnt;
    check({name, " taken"},      64'(pred_taken_out),     64'(et));
    check({name, " target"},     64'(pred_target_out),    64'(etgt));
    check({name, " cnt"},        64'(mispredict_cnt_out), 64'(ecnt_main));
    check({name, " sat_taken"},  64'(sat_pred_taken),     64'(et));
    check({name, " sat_target"}, 64'(sat_pred_target),    64'(etgt));
    check({name, " sat_cnt"},    64'(sat_mis_cnt),        64'(ecnt_sat));
  endtask

  // Same as above but expectations come from the model, which then advances.
  task automatic step_model(input string name, input logic [31:0] lpc, input bit uv,
                            input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                            input bit upred, input bit fl);
    bit          et;
    logic [31:0] etgt;
    et   = m_hit(lpc) && (m_str[slot(lpc)] >= 2);
    etgt = et ? m_tgt[slot(lpc)] : lpc + 32'd4;
    apply_and_check(name, lpc, uv, upc, ut, utgt, upred, fl, et, etgt, m_mis);
    model_update(uv, upc, ut, utgt, upred, fl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_in        = 1'b0;
    update_valid_in = 1'b0;
    flush_in        = 1'b0;
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upred;
    logic        fl;
    logic        et;
    logic [31:0] etgt;
    int          ecnt;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] rand_pc();
    logic [25:0] hi;
    case ($urandom_range(3))
      0:       hi = 26'd0;
      1:       hi = 26'd1;
      2:       hi = 26'd2;
      default: hi = 26'h3FF_FFFF;
    endcase
    return {hi, 4'($urandom_range(15)), 2'($urandom_range(3))};
  endfunction

  initial begin
    //           lpc           uv upc        ut utgt       pr fl  et etgt          cnt
    vt.push_back('{32'h40,       0, 32'h0,    0, 32'h0,    0, 0,  0, 32'h44,       0}); // reset lookup
    vt.push_back('{32'h40,       1, 32'h40,   1, 32'h100,  0, 0,  0, 32'h44,       0}); // allocate, miss seen
    vt.push_back('{32'h40,       1, 32'h40,   0, 32'h0,    1, 0,  1, 32'h100,      1}); // old entry during update
    vt.push_back('{32'h40,       1, 32'h40,   0, 32'h0,    0, 0,  0, 32'h44,       2}); // counter 01
    vt.push_back('{32'h40,       1, 32'h40,   1, 32'h100,  0, 0,  0, 32'h44,       2}); // counter 00
    vt.push_back('{32'h40,       1, 32'h40,   1, 32'h100,  0, 0,  0, 32'h44,       3}); // counter 01
    vt.push_back('{32'h40,       0, 32'h0,    0, 32'h0,    0, 0,  1, 32'h100,      4}); // counter 10
    vt.push_back('{32'h80,       1, 32'h80,   1, 32'h200,  0, 0,  0, 32'h84,       4}); // alias replace
    vt.push_back('{32'h40,       0, 32'h0,    0, 32'h0,    0, 0,  0, 32'h44,       5}); // evicted
    vt.push_back('{32'h80,       0, 32'h0,    0, 32'h0,    0, 0,  1, 32'h200,      5}); // new owner
    vt.push_back('{32'h60,       1, 32'h60,   1, 32'h300,  0, 1,  0, 32'h64,       5}); // flush + update
    vt.push_back('{32'h60,       0, 32'h0,    0, 32'h0,    0, 0,  0, 32'h64,       6}); // no allocation
    vt.push_back('{32'h80,       0, 32'h0,    0, 32'h0,    0, 0,  0, 32'h84,       6}); // flushed
    vt.push_back('{32'hFFFF_FFFC,0, 32'h0,    0, 32'h0,    0, 0,  0, 32'h0,        6}); // +4 wraps
    vt.push_back('{32'h10,       0, 32'h10,   1, 32'h500,  0, 0,  0, 32'h14,       6}); // update ignored
    vt.push_back('{32'h10,       1, 32'h10,   1, 32'h500,  1, 0,  0, 32'h14,       6}); // allocate, correct pred
    vt.push_back('{32'h10,       1, 32'h10,   1, 32'h600,  1, 0,  1, 32'h500,      6}); // counter 11, new target
    vt.push_back('{32'h10,       1, 32'h10,   0, 32'h999,  1, 0,  1, 32'h600,      6}); // counter 10
    vt.push_back('{32'h10,       0, 32'h0,    0, 32'h0,    0, 0,  1, 32'h600,      7}); // target kept on NT
    vt.push_back('{32'h20,       1, 32'h20,   0, 32'h700,  1, 0,  0, 32'h24,       7}); // miss NT: no alloc
    vt.push_back('{32'h20,       0, 32'h0,    0, 32'h0,    0, 0,  0, 32'h24,       8});

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      apply_and_check($sformatf("dir%0d", i), vt[i].lpc, vt[i].uv, vt[i].upc, vt[i].ut,
                      vt[i].utgt, vt[i].upred, vt[i].fl, vt[i].et, vt[i].etgt, vt[i].ecnt);
    end

    // ---- saturation: 20 mispredicted updates ----
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step_model($sformatf("sat%0d", i), 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    end
    @(negedge clk);
    update_valid_in = 1'b0;
    lookup_pc_in    = 32'h40;
    #1;
    check("sat final cnt4",  64'(sat_mis_cnt),        64'd15);
    check("sat final cnt16", 64'(mispredict_cnt_out), 64'd20);
    check("sat final hit",   64'(pred_taken_out),     64'd1);

    // ---- asynchronous reset between edges, with an update pending ----
    update_valid_in  = 1'b1;
    update_pc_in     = 32'h80;
    update_taken_in  = 1'b1;
    update_target_in = 32'h200;
    update_pred_in   = 1'b0;
    #1;
    reset_in = 1'b0;
    #1;
    check("async rst taken",  64'(pred_taken_out),     64'd0);
    check("async rst target", 64'(pred_target_out),    64'h44);
    check("async rst cnt",    64'(mispredict_cnt_out), 64'd0);
    check("async rst cnt4",   64'(sat_mis_cnt),        64'd0);
    @(negedge clk);
    reset_in        = 1'b1;
    update_valid_in = 1'b0;
    model_reset();
    step_model("post rst 0x80", 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step_model("post rst 0x40", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] upc, lpc;
      bit          uv, fl;
      upc = rand_pc();
      lpc = ($urandom_range(2) == 0) ? upc : rand_pc();
      uv  = ($urandom_range(2) != 0);
      fl  = ($urandom_range(39) == 0);
      step_model($sformatf("rnd%0d", i), lpc, uv, upc, 1'($urandom_range(1)),
                 $urandom, 1'($urandom_range(1)), fl);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
